// File: rtl/fifo_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter_pkg
// Shared definitions for the FIFO write arbiter and its round-robin picker:
//   - arb_state_e        : arbiter FSM encoding (ST_IDLE=0, ST_BUSY=1)
//   - RESET_ACTIVE       : level of the reset input that asserts reset
//   - DEFAULT_DATA_WIDTH : default FIFO data width
// ---------------------------------------------------------------------------
package fifo_write_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam logic RESET_ACTIVE       = 1'b0;
    localparam int   DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter_rr_pick
// Combinational round-robin picker. Scans requesters starting one above
// last_owner_i (wrapping explicitly at NUM_REQ-1) and returns the first one
// whose request bit is set. Shared with the read-side arbiter.
//   req_i        in  NUM_REQ   request vector
//   last_owner_i in  IDX_BITS  previous owner; the scan starts just above it
//   winner_o     out IDX_BITS  selected requester (0 when none)
//   valid_o      out 1         1 when any request was found
// ---------------------------------------------------------------------------
module fifo_write_arbiter_rr_pick
    import fifo_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int IDX_BITS = 2
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [IDX_BITS-1:0] last_owner_i,
    output logic [IDX_BITS-1:0] winner_o,
    output logic                valid_o
);

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_REQ - 1);

    logic [IDX_BITS-1:0] scan_idx;

    // NOTE: blocking assignments are correct here -- scan_idx is a loop
    // temporary that must update immediately within this combinational pass.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        scan_idx = last_owner_i;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Explicit wrap keeps the index legal for non-power-of-two counts.
            scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
            if (!valid_o && req_i[scan_idx]) begin
                valid_o  = 1'b1;
                winner_o = scan_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// A grant is held for up to MAX_BURST accepted beats, then released with a
// single IDLE bubble so the next requester can be picked.
//   clk        in  1                   rising-edge clock
//   reset      in  1                   asynchronous reset, active low
//   req        in  NUM_REQ             per-requester level write request
//   req_data   in  NUM_REQ*DATA_WIDTH  packed data, requester i at [i*DW +: DW]
//   ack        out NUM_REQ             one-hot, current word accepted
//   grant      out NUM_REQ             one-hot registered owner, 0 when idle
//   busy       out 1                   FSM is in BUSY
//   fifo_full  in  1                   FIFO full flag
//   fifo_write out 1                   FIFO write strobe
//   fifo_wdata out DATA_WIDTH          FIFO write data, 0 when no grant
// ---------------------------------------------------------------------------
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int IDX_BITS   = 2,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MAX_BURST  = 4,
    parameter int CNT_BITS   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    input  logic                          fifo_full,
    output logic                          fifo_write,
    output logic [DATA_WIDTH-1:0]         fifo_wdata
);

    localparam logic [IDX_BITS-1:0] LAST_IDX  = IDX_BITS'(NUM_REQ - 1);
    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(MAX_BURST - 1);

    arb_state_e          state_q, state_d;
    logic [IDX_BITS-1:0] owner_q, owner_d;
    logic [IDX_BITS-1:0] last_owner_q, last_owner_d;
    logic [CNT_BITS-1:0] burst_cnt_q, burst_cnt_d;

    logic [IDX_BITS-1:0] pick_idx;
    logic                pick_valid;
    logic                owner_req;
    logic                accept;

    fifo_write_arbiter_rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .IDX_BITS (IDX_BITS)
    ) u_rr_pick (
        .req_i        (req),
        .last_owner_i (last_owner_q),
        .winner_o     (pick_idx),
        .valid_o      (pick_valid)
    );

    assign busy      = (state_q == ST_BUSY);
    assign owner_req = req[owner_q];
    // Full gates the strobe directly, so a write can never hit a full FIFO.
    assign accept     = busy && owner_req && !fifo_full;
    assign fifo_write = accept;

    // Grant/ack decode and write-data mux, all keyed by the registered owner.
    always_comb begin
        grant      = '0;
        ack        = '0;
        fifo_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (busy && (owner_q == IDX_BITS'(i))) begin
                grant[i]   = 1'b1;
                ack[i]     = accept;
                fifo_wdata = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // NOTE: every next-state variable gets a default before the case so that
    // paths which do not mention it hold the value instead of inferring a latch.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d     = ST_BUSY;
                    owner_d     = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            ST_BUSY: begin
                if (!owner_req) begin
                    // Owner gave up (possibly abandoning a word): release.
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                end else if (accept) begin
                    if (burst_cnt_q == LAST_BEAT) begin
                        state_d      = ST_IDLE;
                        last_owner_d = owner_q;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end
                // Otherwise the FIFO is full: hold everything, no timeout.
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments for all state so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (reset == RESET_ACTIVE) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= LAST_IDX;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_write_arbiter
// Directed bench for fifo_write_arbiter. Stimulus pushes the expected write
// sequence into a queue; a negedge monitor pops and compares every FIFO write.
// Requesters advance their data word after each ack; an optional FIFO model
// (no reads, DEPTH entries) drives fifo_full.
// ---------------------------------------------------------------------------
module tb_fifo_write_arbiter;

    localparam int NR    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic           clk;
    logic           reset;
    logic [NR-1:0]  req;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]  ack;
    logic [NR-1:0]  grant;
    logic           busy;
    logic           fifo_full;
    logic           fifo_write;
    logic [DW-1:0]  fifo_wdata;

    typedef struct {
        int          idx;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];

    int total       = 0;
    int bad         = 0;
    int writes_seen = 0;

    logic [NR-1:0] ack_seen;
    int  word_idx[NR];
    int  rem[NR];
    int  fcount;
    bit  fifo_model;
    bit  full_drv;

    fifo_write_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .grant      (grant),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_write (fifo_write),
        .fifo_wdata (fifo_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] word(input int i, input int k);
        return DW'(i * 256 + 32'hA0 + k);
    endfunction

    task automatic push(input int i, input int k);
        exp_q.push_back('{idx: i, data: word(i, k)});
    endtask

    // Monitor: compares every presented write against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        ack_seen = ack;
        if (reset) begin
            if (fifo_full) check("write_while_full", fifo_write, 0);
            if (fifo_write) begin
                writes_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", fifo_wdata, 0);
                    check("unexpected_write_flag", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wdata", fifo_wdata, e.data);
                    check("ack_onehot", ack, 4'b0001 << e.idx);
                end
            end else begin
                check("ack_without_write", ack, 0);
            end
        end
    end

    // Requesters advance on ack and drop req when their quota is written.
    task automatic update_producers();
        for (int i = 0; i < NR; i++) begin
            if (ack_seen[i]) begin
                word_idx[i]++;
                if (rem[i] > 0) rem[i]--;
                if (rem[i] == 0) req[i] = 1'b0;
                if (fifo_model) fcount++;
            end
            req_data[i*DW +: DW] = word(i, word_idx[i]);
        end
        fifo_full = full_drv || (fifo_model && fcount >= DEPTH);
    endtask

    // Advance one clock: inputs change just after posedge, return after negedge.
    task automatic cycle();
        @(posedge clk);
        #1;
        update_producers();
        @(negedge clk);
        #1;
    endtask

    task automatic init_producers();
        for (int i = 0; i < NR; i++) begin
            word_idx[i] = 0;
            rem[i]      = 0;
        end
        fcount = 0;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        req        = '0;
        full_drv   = 1'b0;
        fifo_model = 1'b0;
        repeat (2) cycle();
        init_producers();
        update_producers();
        exp_q.delete();
        reset = 1'b1;
    endtask

    task automatic start(input int i, input int n);
        req[i] = 1'b1;
        rem[i] = n;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && !busy && req == '0) && n < 200) begin
            cycle();
            n++;
        end
        check({name, "_drain_timeout"}, n < 200, 1);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        reset      = 1'b0;
        req        = '0;
        req_data   = '0;
        fifo_full  = 1'b0;
        full_drv   = 1'b0;
        fifo_model = 1'b0;
        ack_seen   = '0;
        init_producers();
        repeat (2) cycle();

        // Reset state
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_write", fifo_write, 0);
        check("rst_wdata", fifo_wdata, 0);

        // 1) Single requester, full burst, bubble, re-grant
        do_reset();
        cycle();
        check("t1_idle_grant", grant, 0);
        start(0, 5);
        for (int k = 0; k < 5; k++) push(0, k);
        check("t1_no_grant_yet", grant, 0);
        cycle();
        check("t1_grant", grant, 4'b0001);
        check("t1_busy", busy, 1);
        repeat (3) cycle();
        check("t1_grant_beat4", grant, 4'b0001);
        cycle();
        check("t1_bubble_grant", grant, 0);
        check("t1_bubble_busy", busy, 0);
        cycle();
        check("t1_regrant", grant, 4'b0001);
        drain("t1");

        // 2) All requesters: rotation 0,1,2,3,0,1,2,3 with 4-beat bursts
        do_reset();
        for (int i = 0; i < NR; i++) start(i, 8);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++)
                for (int k = 0; k < 4; k++) push(i, r * 4 + k);
        drain("t2");

        // 3) FIFO full stall in the middle of requester 2's burst
        do_reset();
        start(2, 4);
        for (int k = 0; k < 4; k++) push(2, k);
        cycle();
        check("t3_grant", grant, 4'b0100);
        cycle();
        full_drv = 1'b1;
        for (int s = 0; s < 5; s++) begin
            cycle();
            check("t3_stall_ack", ack, 0);
            check("t3_stall_write", fifo_write, 0);
            check("t3_stall_grant", grant, 4'b0100);
        end
        full_drv = 1'b0;
        cycle();
        check("t3_resume_write", fifo_write, 1);
        cycle();
        check("t3_resume_write2", fifo_write, 1);
        cycle();
        check("t3_release", grant, 0);
        drain("t3");

        // 4) Requester 1 drops after one ack; requester 3 follows
        do_reset();
        start(1, 1);
        start(3, 1);
        push(1, 0);
        push(3, 0);
        cycle();
        check("t4_grant1", grant, 4'b0010);
        cycle();
        check("t4_drop_grant", grant, 4'b0010);
        check("t4_drop_no_write", fifo_write, 0);
        cycle();
        check("t4_idle", grant, 0);
        cycle();
        check("t4_grant3", grant, 4'b1000);
        drain("t4");

        // 5) Asynchronous reset in the middle of a burst
        do_reset();
        start(0, 4);
        for (int k = 0; k < 4; k++) push(0, k);
        drain("t5_pre");
        start(2, 4);
        push(2, 0);
        push(2, 1);
        cycle();
        cycle();
        check("t5_pre_rst_write", fifo_write, 1);
        #2;
        reset = 1'b0;
        #1;
        check("t5_async_grant", grant, 0);
        check("t5_async_ack", ack, 0);
        check("t5_async_write", fifo_write, 0);
        check("t5_async_busy", busy, 0);
        check("t5_queue_empty", exp_q.size(), 0);
        do_reset();
        for (int i = 0; i < NR; i++) begin
            start(i, 1);
            push(i, 0);
        end
        cycle();
        check("t5_first_grant", grant, 4'b0001);
        drain("t5");

        // 6) Streaming into a DEPTH-entry FIFO until it fills
        do_reset();
        fifo_model = 1'b1;
        w0 = writes_seen;
        for (int i = 0; i < NR; i++) start(i, 8);
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < 4; k++) push(i, k);
        repeat (30) cycle();
        check("t6_writes", writes_seen - w0, DEPTH);
        check("t6_queue_empty", exp_q.size(), 0);
        check("t6_full", fifo_full, 1);
        check("t6_stall_ack", ack, 0);
        check("t6_stall_write", fifo_write, 0);
        check("t6_stall_grant", grant, 4'b0001);
        do_reset();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
